// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM states, fault causes and access-size helpers
package lsu_pkg;
  localparam logic [2:0] F3_LB = 3'd0, F3_LH = 3'd1, F3_LW = 3'd2, F3_LBU = 3'd4, F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB = 3'd0, F3_SH = 3'd1, F3_SW = 3'd2;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_FAULT} state_e;
  typedef enum logic [1:0] {C_NONE, C_MISALIGN, C_TIMEOUT, C_FUNCT3} cause_e;
  function automatic logic [2:0] size_from_funct3(input logic [2:0] f3);
    return f3[1:0] == 2'd0 ? 3'd1 : f3[1:0] == 2'd1 ? 3'd2 : 3'd4;
  endfunction
  function automatic logic funct3_bad(input logic store, input logic [2:0] f3);
    return store ? f3 > F3_SW : (f3[1:0] == 2'd3 || f3 > F3_LHU);
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: maps an access onto bus byte lanes and gathers/extends read bytes
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int BUS_BYTES = 1
) (
  input  logic [1:0]             offset_i,
  input  logic [2:0]             funct3_i,
  input  logic [1:0]             beat_i,
  input  logic [31:0]            wdata_i,
  input  logic [8*BUS_BYTES-1:0] lanes_i,
  input  logic [31:0]            raw_i,
  output logic [BUS_BYTES-1:0]   wstrb_o,
  output logic [8*BUS_BYTES-1:0] lanes_o,
  output logic [31:0]            raw_o,
  output logic [31:0]            ext_o
);
  localparam int LW = 8 * BUS_BYTES;
  localparam logic [1:0] OMASK = 2'(BUS_BYTES - 1);
  logic [2:0] size;
  logic narrow;
  logic [1:0] off;
  logic [5:0] nsh, bsh;
  logic [BUS_BYTES-1:0] smask;
  logic [31:0] rd, rmask;
  // Narrow accesses sit at the lane offset in one beat; wide ones take BUS_BYTES slices per beat
  always_comb begin
    size = size_from_funct3(funct3_i);
    narrow = size < 3'(BUS_BYTES);
    off = offset_i & OMASK;
    nsh = {1'b0, off, 3'b000};
    bsh = 6'(beat_i) * 6'(LW);
    smask = size == 3'd1 ? BUS_BYTES'(1) : BUS_BYTES'(3);
    wstrb_o = narrow ? smask << off : '1;
    lanes_o = LW'(narrow ? wdata_i << nsh : wdata_i >> bsh);
    rd = narrow ? 32'(lanes_i) >> nsh : 32'(lanes_i) << bsh;
    rmask = narrow ? '1 : 32'({LW{1'b1}}) << bsh;
    raw_o = (raw_i & ~rmask) | (rd & rmask);
    ext_o = funct3_i == F3_LB ? {{24{raw_o[7]}}, raw_o[7:0]} :
            funct3_i == F3_LH ? {{16{raw_o[15]}}, raw_o[15:0]} :
            funct3_i == F3_LBU ? {24'd0, raw_o[7:0]} :
            funct3_i == F3_LHU ? {16'd0, raw_o[15:0]} : raw_o;
  end
endmodule

// File: rtl/lsu_sequencer.sv
// lsu_sequencer: splits one RV32I load/store into bus beats with req/ack, timeout and fault reporting
module lsu_sequencer
  import lsu_pkg::*;
#(
  parameter int BUS_BYTES = 1,
  parameter int TIMEOUT   = 15
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  input  logic                   i_store,
  input  logic [2:0]             i_funct3,
  input  logic [31:0]            i_addr,
  input  logic [31:0]            i_wdata,
  output logic                   o_ready,
  output logic                   o_done,
  output logic                   o_fault,
  output logic [1:0]             o_fault_cause,
  output logic [31:0]            o_rdata,
  output logic                   o_mem_req,
  output logic                   o_mem_write,
  output logic [31:0]            o_mem_addr,
  output logic [8*BUS_BYTES-1:0] o_mem_wdata,
  output logic [BUS_BYTES-1:0]   o_mem_wstrb,
  input  logic [8*BUS_BYTES-1:0] i_mem_rdata,
  input  logic                   i_mem_ack
);
  localparam logic [15:0] TMO = 16'(TIMEOUT);
  state_e state_q, state_d;
  cause_e cause_q, cause_d;
  logic [1:0] beat_q, beat_d;
  logic [15:0] tmo_q, tmo_d;
  logic store_q, store_d;
  logic [2:0] f3_q, f3_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, raw_q, raw_d, rdata_q, rdata_d;
  logic [2:0] sz_i, sz_q;
  logic bad_i, mis_i, last;
  logic [31:0] beat_addr, raw_m, ext;
  logic [BUS_BYTES-1:0] strb;
  logic [8*BUS_BYTES-1:0] lanes;

  lsu_lane_align #(.BUS_BYTES(BUS_BYTES)) u_align (
    .offset_i(addr_q[1:0]),
    .funct3_i(f3_q),
    .beat_i  (beat_q),
    .wdata_i (wdata_q),
    .lanes_i (i_mem_rdata),
    .raw_i   (raw_q),
    .wstrb_o (strb),
    .lanes_o (lanes),
    .raw_o   (raw_m),
    .ext_o   (ext)
  );

  // Decode the incoming request and locate the current beat of the latched one
  always_comb begin
    sz_i = size_from_funct3(i_funct3);
    bad_i = funct3_bad(i_store, i_funct3);
    mis_i = (i_addr[1:0] & 2'(sz_i - 3'd1)) != 2'd0;
    sz_q = size_from_funct3(f3_q);
    last = beat_q == (sz_q > 3'(BUS_BYTES) ? 2'(sz_q / 3'(BUS_BYTES) - 3'd1) : 2'd0);
    beat_addr = (addr_q & ~32'(BUS_BYTES - 1)) + (32'(beat_q) << $clog2(BUS_BYTES));
  end

  // Next state: accept/fault decision, beat stepping, timeout and load capture
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    beat_d = beat_q;
    tmo_d = tmo_q;
    store_d = store_q;
    f3_d = f3_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    raw_d = raw_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: if (i_valid) begin
        store_d = i_store;
        f3_d = i_funct3;
        addr_d = i_addr;
        wdata_d = i_wdata;
        beat_d = 2'd0;
        tmo_d = 16'd0;
        cause_d = bad_i ? C_FUNCT3 : mis_i ? C_MISALIGN : C_NONE;
        state_d = bad_i || mis_i ? S_FAULT : S_REQ;
      end
      S_REQ: if (i_mem_ack) begin
        tmo_d = 16'd0;
        raw_d = store_q ? raw_q : raw_m;
        rdata_d = last && !store_q ? ext : rdata_q;
        beat_d = last ? beat_q : beat_q + 2'd1;
        state_d = last ? S_DONE : S_REQ;
      end else if (TIMEOUT != 0 && tmo_q + 16'd1 == TMO) begin
        cause_d = C_TIMEOUT;
        state_d = S_FAULT;
      end else begin
        tmo_d = tmo_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cause_q <= C_NONE;
      beat_q <= 2'd0;
      tmo_q <= 16'd0;
      store_q <= 1'b0;
      f3_q <= 3'd0;
      addr_q <= 32'd0;
      wdata_q <= 32'd0;
      raw_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      beat_q <= beat_d;
      tmo_q <= tmo_d;
      store_q <= store_d;
      f3_q <= f3_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      raw_q <= raw_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_ready = state_q == S_IDLE;
  assign o_done = state_q == S_DONE || state_q == S_FAULT;
  assign o_fault = state_q == S_FAULT;
  assign o_fault_cause = state_q == S_FAULT ? cause_q : C_NONE;
  assign o_rdata = rdata_q;
  assign o_mem_req = state_q == S_REQ;
  assign o_mem_write = o_mem_req && store_q;
  assign o_mem_addr = o_mem_req ? beat_addr : '0;
  assign o_mem_wdata = o_mem_write ? lanes : '0;
  assign o_mem_wstrb = o_mem_req ? strb : '0;
endmodule

// File: tb/tb_lsu_sequencer.sv
// tb_lsu_sequencer: directed and random load/store checks at bus widths 1, 2 and 4 bytes
module tb_lsu_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic valid = 1'b0, store = 1'b0;
  logic [2:0] funct3 = 3'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0, peek_addr = 32'd0;
  logic no_ack = 1'b0, rnd_wait = 1'b0;
  int max_wait = 0;
  int n_chk = 0, n_fail = 0;
  logic [7:0] ref_mem [1024];
  logic [31:0] exp_rdata = 32'd0;
  wire [2:0] seen, ready_v, req_v, done_v, flt_v, fault_v;
  wire [1:0] cz_v [3];
  wire [1:0] cause_v [3];
  wire [31:0] rdata_v [3];
  wire [31:0] word_v [3];
  wire [31:0] beats_v [3];
  wire [31:0] reqc_v [3];
  wire [31:0] dcyc_v [3];
  wire [31:0] aerr_v [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_bus
    localparam int B = 1 << g;
    logic ready, done, fault, req, wr, ack, seen_q = 1'b0, fault_q = 1'b0;
    logic [1:0] cause, cause_q = 2'd0;
    logic [31:0] rdata, maddr;
    logic [8*B-1:0] mwdata, mrdata;
    logic [B-1:0] wstrb;
    logic [7:0] mem [1024];
    int wait_left = 0, beats = 0, reqc = 0, cyc = 0, dcyc = 0, aerr = 0;
    lsu_sequencer #(.BUS_BYTES(B), .TIMEOUT(15)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_store(store), .i_funct3(funct3),
      .i_addr(addr), .i_wdata(wdata), .o_ready(ready), .o_done(done), .o_fault(fault),
      .o_fault_cause(cause), .o_rdata(rdata), .o_mem_req(req), .o_mem_write(wr),
      .o_mem_addr(maddr), .o_mem_wdata(mwdata), .o_mem_wstrb(wstrb),
      .i_mem_rdata(mrdata), .i_mem_ack(ack));
    initial for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 73 + 11);
    assign ack = req && !no_ack && wait_left == 0;
    always_comb begin
      mrdata = '0;
      for (int l = 0; l < B; l++) mrdata[8*l +: 8] = mem[10'(maddr + 32'(l))];
    end
    always @(posedge clk) begin
      if (req && ack && wr)
        for (int l = 0; l < B; l++) if (wstrb[l]) mem[10'(maddr + 32'(l))] <= mwdata[8*l +: 8];
      if (rst) seen_q <= 1'b0;
      else if (valid && ready) begin
        seen_q <= 1'b0; beats <= 0; reqc <= 0; cyc <= 1; aerr <= 0;
        wait_left <= rnd_wait ? int'($urandom_range(max_wait, 0)) : max_wait;
      end else begin
        cyc <= cyc + 1;
        if (req) begin
          reqc <= reqc + 1;
          if (maddr != (addr & ~32'(B - 1)) + 32'(beats * B) || wr != store) aerr <= aerr + 1;
          if (ack) begin
            beats <= beats + 1;
            wait_left <= rnd_wait ? int'($urandom_range(max_wait, 0)) : max_wait;
          end else if (wait_left > 0) wait_left <= wait_left - 1;
        end
        if (done) begin seen_q <= 1'b1; dcyc <= cyc; fault_q <= fault; cause_q <= cause; end
      end
    end
    assign seen[g] = seen_q;
    assign ready_v[g] = ready;
    assign req_v[g] = req;
    assign done_v[g] = done;
    assign flt_v[g] = fault;
    assign cz_v[g] = cause;
    assign fault_v[g] = fault_q;
    assign cause_v[g] = cause_q;
    assign rdata_v[g] = rdata;
    assign beats_v[g] = beats;
    assign reqc_v[g] = reqc;
    assign dcyc_v[g] = dcyc;
    assign aerr_v[g] = aerr;
    assign word_v[g] = {mem[10'(peek_addr + 32'd3)], mem[10'(peek_addr + 32'd2)],
                        mem[10'(peek_addr + 32'd1)], mem[10'(peek_addr)]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int sz, nb, cz, lim, xreq;
    logic [31:0] v, pa;
    sz = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    cz = (st ? f3 >= 3'd3 : (f3[1:0] == 2'd3 || f3 >= 3'd6)) ? 3 : (a % sz) != 0 ? 1 : no_ack ? 2 : 0;
    pa = a & ~32'd3;
    @(negedge clk);
    valid = 1'b1; store = st; funct3 = f3; addr = a; wdata = wd; peek_addr = pa;
    @(negedge clk);
    valid = 1'b0;
    for (lim = 0; lim < 200 && seen != 3'b111; lim++) @(negedge clk);
    chk("completion", 32'(seen), 32'd7);
    if (cz == 0 && !st) begin
      v = 32'd0;
      for (int i = 0; i < sz; i++) v |= 32'(ref_mem[10'(a + 32'(i))]) << (8 * i);
      exp_rdata = f3 == 3'd0 ? {{24{v[7]}}, v[7:0]} : f3 == 3'd1 ? {{16{v[15]}}, v[15:0]} : v;
    end
    if (cz == 0 && st) for (int i = 0; i < sz; i++) ref_mem[10'(a + 32'(i))] = wd[8*i +: 8];
    for (int g = 0; g < 3; g++) begin
      nb = sz > (1 << g) ? sz >> g : 1;
      xreq = cz == 2 ? 15 : cz != 0 ? 0 : nb * (max_wait + 1);
      chk($sformatf("fault[%0d]", g), 32'(fault_v[g]), 32'(cz != 0));
      chk($sformatf("cause[%0d]", g), 32'(cause_v[g]), 32'(cz));
      chk($sformatf("rdata[%0d]", g), rdata_v[g], exp_rdata);
      chk($sformatf("beats[%0d]", g), beats_v[g], 32'(cz == 0 ? nb : 0));
      chk($sformatf("done_cycle[%0d]", g), dcyc_v[g], reqc_v[g] + 32'd1);
      chk($sformatf("beat_addr[%0d]", g), aerr_v[g], 32'd0);
      if (!rnd_wait || cz != 0) chk($sformatf("req_cycles[%0d]", g), reqc_v[g], 32'(xreq));
      chk($sformatf("mem_word[%0d]", g), word_v[g],
          {ref_mem[10'(pa + 32'd3)], ref_mem[10'(pa + 32'd2)], ref_mem[10'(pa + 32'd1)], ref_mem[10'(pa)]});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got %0d checks, required completion", n_chk);
    $fatal(1);
  end

  initial begin
    logic st;
    logic [2:0] f3;
    logic [31:0] a;
    logic [2:0] lcodes [5];
    lcodes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 73 + 11);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_ready", 32'(ready_v), 32'd7);
    chk("reset_done", 32'(done_v), 32'd0);
    chk("reset_fault", 32'(flt_v), 32'd0);
    chk("reset_req", 32'(req_v), 32'd0);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("reset_cause[%0d]", g), 32'(cz_v[g]), 32'd0);
      chk($sformatf("reset_rdata[%0d]", g), rdata_v[g], 32'd0);
    end
    run_op(1'b1, 3'd2, 32'h100, 32'h12345678);
    run_op(1'b0, 3'd2, 32'h100, 32'h0);
    chk("lw_0x100", exp_rdata, 32'h12345678);
    run_op(1'b1, 3'd0, 32'h40, 32'h80);
    run_op(1'b0, 3'd0, 32'h40, 32'h0);
    run_op(1'b0, 3'd4, 32'h40, 32'h0);
    run_op(1'b1, 3'd1, 32'h202, 32'hAABBCCDD);
    max_wait = 2;
    run_op(1'b0, 3'd2, 32'h10, 32'h0);
    max_wait = 0;
    run_op(1'b0, 3'd2, 32'h101, 32'h0);
    run_op(1'b0, 3'd3, 32'h20, 32'h0);
    run_op(1'b1, 3'd4, 32'h20, 32'h55);
    no_ack = 1'b1;
    run_op(1'b0, 3'd2, 32'h10, 32'h0);
    run_op(1'b1, 3'd2, 32'h30, 32'hDEADBEEF);
    no_ack = 1'b0;
    @(negedge clk);
    valid = 1'b1; store = 1'b0; funct3 = 3'd2; addr = 32'h80;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    chk("mid_req", 32'(req_v[1:0]), 32'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_ready", 32'(ready_v), 32'd7);
    chk("rst_mid_req", 32'(req_v), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_rdata = 32'd0;
    for (int g = 0; g < 3; g++) chk($sformatf("rst_mid_rdata[%0d]", g), rdata_v[g], 32'd0);
    rnd_wait = 1'b1;
    repeat (150) begin
      max_wait = int'($urandom_range(2, 0));
      no_ack = $urandom_range(19, 0) == 0;
      st = $urandom_range(2, 0) == 0;
      f3 = $urandom_range(9, 0) < 2 ? 3'($urandom_range(7, 0)) :
           st ? 3'($urandom_range(2, 0)) : lcodes[$urandom_range(4, 0)];
      a = $urandom;
      if ($urandom_range(3, 0) != 0) a = a & ~32'((f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4) - 1);
      run_op(st, f3, a, $urandom);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_sequencer.md
Name: lsu_sequencer

Overview:
- Parametrised load/store sequencer sitting between the execute stage and the data memory port.
- Accepts one RV32I load/store (LB/LH/LW/LBU/LHU/SB/SH/SW) at a time and splits it into one or more memory beats on a bus of BUS_BYTES bytes.
- Uses a req/ack handshake that tolerates wait states, and applies sign or zero extension to load results.
- Reports misalignment, bad funct3 and ack timeout as faults, so the execute stage no longer sequences memory itself.

Parameters:
- BUS_BYTES, 1, bytes per memory beat; legal values 1, 2, 4.
- TIMEOUT, 15, max cycles o_mem_req may wait for i_mem_ack before faulting; 0 disables the timeout.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_valid  in  1  start request; sampled only while o_ready=1
- i_store  in  1  1=store, 0=load
- i_funct3  in  3  RV32I load/store funct3
- i_addr  in  32  effective byte address
- i_wdata  in  32  store data (rs2 value)
- o_ready  out  1  sequencer idle, can accept
- o_done  out  1  one-cycle completion pulse
- o_fault  out  1  qualifies o_done; operation failed
- o_fault_cause  out  2  0 none, 1 misaligned, 2 timeout, 3 bad funct3
- o_rdata  out  32  extended load result; valid with o_done, held until next accept
- o_mem_req  out  1  beat request
- o_mem_write  out  1  beat is a write
- o_mem_addr  out  32  beat address, aligned to BUS_BYTES
- o_mem_wdata  out  8*BUS_BYTES  write data lanes
- o_mem_wstrb  out  BUS_BYTES  byte-lane enables (write and read)
- i_mem_rdata  in  8*BUS_BYTES  read data lanes
- i_mem_ack  in  1  beat complete in the current cycle

Behaviour:
- Reset values:
  - Outputs: o_ready=1; o_done, o_fault, o_mem_req, o_mem_write=0; o_fault_cause=0; o_rdata, o_mem_addr, o_mem_wdata, o_mem_wstrb=0.
  - Internal: beat counter and timeout counter=0; state IDLE.
- Reset mid-transfer: state returns to IDLE on the next edge and o_mem_req drops that edge. A pending beat is abandoned; memory side-effects already acked are not undone.
- States: IDLE, REQ, DONE, FAULT.
- IDLE, i_valid=1: latch all inputs. Size S = 1/2/4 from funct3[1:0].
  - funct3 invalid (loads 3,6,7; stores >=3) -> FAULT with cause 3.
  - i_addr mod S != 0 -> FAULT with cause 1.
  - Otherwise -> REQ.
  - FAULT has priority over REQ; no memory request is issued on a fault.
- Beats: NB = max(1, S/BUS_BYTES). Byte order is little-endian.
  - Beat k address = (i_addr & ~(BUS_BYTES-1)) + k*BUS_BYTES.
  - If S < BUS_BYTES: one beat; strobe = S ones shifted by i_addr mod BUS_BYTES; data on the matching lanes.
  - Otherwise all strobes are 1 and beat k carries bytes k*BUS_BYTES.. of the operand.
- REQ:
  - o_mem_req=1. Address, wdata, wstrb and write are stable until ack.
  - Beat completes on any edge where i_mem_ack=1 (zero-wait ack in the same cycle is legal).
  - Load lanes are captured on the ack edge.
  - Ack on the last beat -> DONE. Otherwise the beat counter increments and REQ continues with the next address, with no idle cycle between beats.
- Timeout:
  - Counter clears on every ack.
  - If TIMEOUT>0 and the counter reaches TIMEOUT with no ack: -> FAULT with cause 2, and o_mem_req drops.
  - Ack and timeout on the same cycle: ack wins.
- DONE and FAULT:
  - One cycle each, with o_done=1; FAULT also drives o_fault=1. Then -> IDLE.
  - o_ready=0 in DONE and FAULT, so back-to-back accept is possible on the following cycle.
- Extension:
  - LB and LH sign-extend from bit 7 / bit 15.
  - LBU and LHU zero-extend.
  - Stores leave o_rdata unchanged.
- Latency, zero-wait memory: accept at edge 0; o_mem_req high in cycles 1..NB; o_done in cycle NB+1. Fault cases: o_done in cycle 1.
- i_valid is ignored when o_ready=0.
- i_mem_ack is ignored when o_mem_req=0.

Decomposition:
- Shared package lsu_pkg:
  - funct3 codes (LB..LHU, SB..SW).
  - State enum.
  - Fault-cause enum.
  - size_from_funct3 function.
- One sub-module, lsu_lane_align (combinational): given offset, size and BUS_BYTES, produces wstrb, shifts write data onto lanes, and extracts/extends read bytes.
- The FSM and counters stay in lsu_sequencer.

Test Plan:
- BUS_BYTES=1, LW at 0x100, memory 0x100..0x103 = 78,56,34,12, zero-wait.
  -> req addrs 0x100..0x103 on consecutive cycles; o_done cycle 5; o_rdata=0x12345678.
- BUS_BYTES=1, LB at 0x40 holding 0x80.
  -> o_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080.
- BUS_BYTES=4, SH at 0x202, wdata 0xAABBCCDD.
  -> one beat, addr 0x200, wstrb 1100, wdata[31:16]=0xCCDD, o_mem_write=1.
- BUS_BYTES=2, LW at 0x10 with a 3-cycle ack delay per beat.
  -> addr 0x10 held 3 cycles, then 0x12 held 3 cycles; o_done after the second ack; no fault.
- LW at 0x101.
  -> o_done=o_fault=1 with cause 1 in cycle 1; o_mem_req never asserted. funct3=3 load -> cause 3.
- TIMEOUT=15, ack never asserted -> fault with cause 2 after 15 req cycles.
  - Separately: assert i_rst during beat 2 of an LW -> o_mem_req=0 and o_ready=1 next cycle.
